if_fetch_stage: RTL and testbench

Instruction-fetch stage feeding the IF/ID pipeline register. It holds the program counter and issues single-outstanding requests to an instruction memory over a gnt/rvalid handshake. It presents pc, pc+4 and the fetched instruction to IF/ID, presents a NOP bubble when no instruction is ready, and handles stalls (stop) and redirects (jump), including discarding responses that are in flight when a redirect occurs.

---
 rtl/if_fetch_stage.sv | 112 +++++++++++
 tb/tb_if_fetch_stage.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one request at a time to the
// instruction memory over a gnt/rvalid handshake, and presents pc, pc+4 and
// the fetched word (or a NOP bubble) to the IF/ID pipeline register.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stop,
    input  logic        jump,
    input  logic [31:0] jump_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o,
    output logic [31:0] inst_o,
    output logic        inst_valid
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] jump_tgt;

    // Redirect targets are always word aligned.
    assign jump_tgt = {jump_addr[31:2], 2'b00};

    // State, PC and instruction registers; reset restarts fetching at RESET_PC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    // Next-state logic: jump always wins; a response that belongs to a
    // redirected-away request is discarded via DROP.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        case (state_q)
            S_FETCH: begin
                if (jump) begin
                    pc_d = jump_tgt;
                    if (imem_gnt) begin
                        state_d = S_DROP;
                    end
                end else if (imem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (jump) begin
                    pc_d    = jump_tgt;
                    state_d = imem_rvalid ? S_FETCH : S_DROP;
                end else if (imem_rvalid) begin
                    inst_d  = imem_rdata;
                    state_d = S_VALID;
                end
            end
            S_VALID: begin
                if (jump) begin
                    pc_d    = jump_tgt;
                    state_d = S_FETCH;
                end else if (!stop) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = S_FETCH;
                end
            end
            S_DROP: begin
                // A jump only retargets the PC; the stale response still
                // retires the outstanding request, so rvalid always leaves
                // DROP (otherwise a coincident jump would wait forever).
                if (jump) begin
                    pc_d = jump_tgt;
                end
                if (imem_rvalid) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Outputs depend on registers only, never on inputs.
    assign imem_req   = (state_q == S_FETCH);
    assign imem_addr  = pc_q;
    assign pc_o       = pc_q;
    assign pc4_o      = pc_q + 32'd4;
    assign inst_valid = (state_q == S_VALID);
    assign inst_o     = (state_q == S_VALID) ? inst_q : NOP_INST;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: the bench plays the instruction
// memory, pushes the expected (pc, inst) pair whenever it returns a response
// that must be presented, and pops/compares when inst_valid rises.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        stop;
    logic        jump;
    logic [31:0] jump_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc_o;
    logic [31:0] pc4_o;
    logic [31:0] inst_o;
    logic        inst_valid;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    if_fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .stop       (stop),
        .jump       (jump),
        .jump_addr  (jump_addr),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .pc_o       (pc_o),
        .pc4_o      (pc4_o),
        .inst_o     (inst_o),
        .inst_valid (inst_valid)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one clock and settle 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From FETCH: grant now, respond next cycle, leaving the DUT in VALID.
    task automatic complete_fetch(input logic [31:0] pc, input logic [31:0] data);
        exp_t e;
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        e.pc   = pc;
        e.inst = data;
        sb.push_back(e);
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
    endtask

    // Wait (bounded) for inst_valid, then compare against the scoreboard head.
    task automatic expect_presented(input string name);
        exp_t e;
        int   n = 0;
        while (!inst_valid && n < 5) begin
            tick();
            n++;
        end
        checks++;
        if (!inst_valid) begin
            errors++;
            $display("[TB] FAIL %s_timeout: inst_valid=%b required 1", name, inst_valid);
        end else if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s_sb: inst_valid=1 but scoreboard empty (required no instruction)", name);
        end else begin
            e = sb.pop_front();
            if (pc_o !== e.pc || pc4_o !== e.pc + 32'd4 || inst_o !== e.inst) begin
                errors++;
                $display("[TB] FAIL %s_data: pc=%h pc4=%h inst=%h required pc=%h pc4=%h inst=%h",
                         name, pc_o, pc4_o, inst_o, e.pc, e.pc + 32'd4, e.inst);
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || pc_o !== 32'h0 ||
            pc4_o !== 32'h4 || inst_o !== NOP || inst_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: req=%b addr=%h pc=%h pc4=%h inst=%h v=%b required 1 0 0 4 %h 0",
                     imem_req, imem_addr, pc_o, pc4_o, inst_o, inst_valid, NOP);
        end
    endtask

    task automatic test_zero_wait();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL zw_first_req: req=%b addr=%h required 1 00000000", imem_req, imem_addr);
        end
        complete_fetch(32'h0, 32'h0050_0093);
        expect_presented("zw");
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4 || inst_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zw_next_req: req=%b addr=%h v=%b required 1 00000004 0",
                     imem_req, imem_addr, inst_valid);
        end
    endtask

    task automatic test_stall();
        complete_fetch(32'h4, 32'h00a0_0113);
        expect_presented("stall");
        stop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (inst_valid !== 1'b1 || pc_o !== 32'h4 || inst_o !== 32'h00a0_0113 || imem_req !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_hold%0d: v=%b pc=%h inst=%h req=%b required 1 00000004 00a00113 0",
                         i, inst_valid, pc_o, inst_o, imem_req);
            end
        end
        stop = 1'b0;
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8 || inst_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_release: req=%b addr=%h v=%b required 1 00000008 0",
                     imem_req, imem_addr, inst_valid);
        end
    endtask

    task automatic test_jump_wait();
        imem_gnt = 1'b1;
        tick();
        imem_gnt  = 1'b0;
        jump      = 1'b1;
        jump_addr = 32'h0000_0103;
        tick();
        jump = 1'b0;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h100 || inst_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL jw_drop: req=%b addr=%h v=%b required 0 00000100 0",
                     imem_req, imem_addr, inst_valid);
        end
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100 || inst_valid !== 1'b0 || inst_o !== NOP) begin
            errors++;
            $display("[TB] FAIL jw_discard: req=%b addr=%h v=%b inst=%h required 1 00000100 0 %h",
                     imem_req, imem_addr, inst_valid, inst_o, NOP);
        end
        // Jump coinciding with the response in WAIT: data dropped, straight to FETCH.
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        jump        = 1'b1;
        jump_addr   = 32'h0000_0202;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1111_1111;
        tick();
        jump        = 1'b0;
        imem_rvalid = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200 || inst_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL jw_rvalid_same: req=%b addr=%h v=%b required 1 00000200 0",
                     imem_req, imem_addr, inst_valid);
        end
    endtask

    task automatic test_jump_gnt_and_stop();
        imem_gnt  = 1'b1;
        jump      = 1'b1;
        jump_addr = 32'h0000_0300;
        tick();
        imem_gnt = 1'b0;
        jump     = 1'b0;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h300) begin
            errors++;
            $display("[TB] FAIL jg_drop: req=%b addr=%h required 0 00000300", imem_req, imem_addr);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h2222_2222;
        tick();
        imem_rvalid = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h300 || inst_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL jg_stale: req=%b addr=%h v=%b required 1 00000300 0",
                     imem_req, imem_addr, inst_valid);
        end
        // Retargeting while in DROP: the newest target wins.
        imem_gnt  = 1'b1;
        jump      = 1'b1;
        jump_addr = 32'h0000_0500;
        tick();
        imem_gnt  = 1'b0;
        jump_addr = 32'h0000_0601;
        tick();
        jump        = 1'b0;
        imem_rvalid = 1'b1;
        tick();
        imem_rvalid = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h600 || inst_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL jg_newest: req=%b addr=%h v=%b required 1 00000600 0",
                     imem_req, imem_addr, inst_valid);
        end
        complete_fetch(32'h600, 32'h0030_0193);
        expect_presented("js");
        stop      = 1'b1;
        jump      = 1'b1;
        jump_addr = 32'h0000_0400;
        tick();
        stop = 1'b0;
        jump = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h400 || inst_o !== NOP) begin
            errors++;
            $display("[TB] FAIL js_jump_wins: v=%b req=%b addr=%h inst=%h required 0 1 00000400 %h",
                     inst_valid, imem_req, imem_addr, inst_o, NOP);
        end
    endtask

    task automatic test_pc_wrap();
        jump      = 1'b1;
        jump_addr = 32'hFFFF_FFFF;
        tick();
        jump = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("[TB] FAIL wrap_target: req=%b addr=%h required 1 fffffffc", imem_req, imem_addr);
        end
        complete_fetch(32'hFFFF_FFFC, 32'h0040_0213);
        expect_presented("wrap");
        checks++;
        if (pc4_o !== 32'h0) begin
            errors++;
            $display("[TB] FAIL wrap_pc4: pc4=%h required 00000000", pc4_o);
        end
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL wrap_next: req=%b addr=%h required 1 00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_async_reset();
        jump      = 1'b1;
        jump_addr = 32'h0000_0800;
        tick();
        jump     = 1'b0;
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h800) begin
            errors++;
            $display("[TB] FAIL ar_in_wait: req=%b addr=%h required 0 00000800", imem_req, imem_addr);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || pc_o !== 32'h0 || pc4_o !== 32'h4 ||
            inst_o !== NOP || inst_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ar_immediate: req=%b addr=%h pc=%h pc4=%h inst=%h v=%b required 1 0 0 4 %h 0",
                     imem_req, imem_addr, pc_o, pc4_o, inst_o, inst_valid, NOP);
        end
        #2;
        reset = 1'b0;
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ar_release: req=%b addr=%h v=%b required 1 00000000 0",
                     imem_req, imem_addr, inst_valid);
        end
    endtask

    // Test sequence.
    initial begin
        reset       = 1'b1;
        stop        = 1'b0;
        jump        = 1'b0;
        jump_addr   = 32'h0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        #2;
        test_reset();
        tick();
        reset = 1'b0;
        test_zero_wait();
        test_stall();
        test_jump_wait();
        test_jump_gnt_and_stop();
        test_pc_wrap();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL sb_drain: %0d entries left required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
